top_h_line_cfg_ctrl: RTL and testbench



---
 rtl/top_h_line_cfg_ctrl_if.sv | 24 ++
 rtl/top_h_line_cfg_ctrl.sv | 100 ++++++++++
 tb/tb_top_h_line_cfg_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/top_h_line_cfg_ctrl_if.sv
// rtl/top_h_line_cfg_ctrl_if.sv - configuration request handshake bundle for one pad line
interface top_h_line_cfg_ctrl_if;
    logic       cfg_valid;
    logic [3:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_err;
    logic       cfg_busy;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  cfg_err,
        input  cfg_busy
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output cfg_err,
        output cfg_busy
    );
endinterface

// File: rtl/top_h_line_cfg_ctrl.sv
// rtl/top_h_line_cfg_ctrl.sv - line configuration controller with break-before-make OE blanking
module top_h_line_cfg_ctrl #(
    parameter int         W             = 10,
    parameter int         BLANK_CYCLES  = 4,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] RESET_CFG     = 4'd0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    top_h_line_cfg_ctrl_if.slave        cfg,
    output logic [3:0]                  configuration,
    input  logic [W-1:0]                north_o_selected,
    input  logic [W-1:0]                north_oe_selected,
    output logic [W-1:0]                north_o_pad,
    output logic [W-1:0]                north_oe_pad
);

    localparam int MAX_CYC = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        BLANK  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pending;
    logic             err_q;

    logic hs;
    logic legal;
    logic switch_hs;

    // A switching handshake is a legal request for a code other than the current one.
    always_comb begin
        hs        = cfg.cfg_valid && (state == ACTIVE);
        legal     = (cfg.cfg_data <= 4'd3);
        switch_hs = hs && legal && (cfg.cfg_data != configuration);
    end

    assign cfg.cfg_ready = (state == ACTIVE);
    assign cfg.cfg_busy  = (state != ACTIVE);
    assign cfg.cfg_err   = err_q;

    // Sequencer: OE is blanked for BLANK cycles, mux switches, then OE stays blanked for SETTLE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SETTLE;
            cnt           <= CNT_W'(SETTLE_CYCLES - 1);
            configuration <= RESET_CFG;
            pending       <= RESET_CFG;
            err_q         <= 1'b0;
        end else begin
            err_q <= hs && !legal;
            case (state)
                ACTIVE: begin
                    if (switch_hs) begin
                        pending <= cfg.cfg_data;
                        state   <= BLANK;
                        cnt     <= CNT_W'(BLANK_CYCLES - 1);
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        configuration <= pending;
                        state         <= SETTLE;
                        cnt           <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= ACTIVE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                end
            endcase
        end
    end

    // Pad stage: data passes straight through, OE is gated off outside ACTIVE and on the switching edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            north_o_pad  <= '0;
            north_oe_pad <= '0;
        end else begin
            north_o_pad  <= north_o_selected;
            north_oe_pad <= ((state == ACTIVE) && !switch_hs) ? north_oe_selected : '0;
        end
    end

endmodule

// File: tb/tb_top_h_line_cfg_ctrl.sv
// tb/tb_top_h_line_cfg_ctrl.sv - vector table plus hand sequences for the line configuration controller
module tb_top_h_line_cfg_ctrl;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   configuration;
    logic [W-1:0] o_sel;
    logic [W-1:0] oe_sel;
    logic [W-1:0] o_pad;
    logic [W-1:0] oe_pad;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    top_h_line_cfg_ctrl_if cfg_if ();

    top_h_line_cfg_ctrl #(
        .W(W), .BLANK_CYCLES(4), .SETTLE_CYCLES(2), .RESET_CFG(4'd0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg               (cfg_if),
        .configuration     (configuration),
        .north_o_selected  (o_sel),
        .north_oe_selected (oe_sel),
        .north_o_pad       (o_pad),
        .north_oe_pad      (oe_pad)
    );

    typedef struct {
        logic         valid;
        logic [3:0]   data;
        logic [W-1:0] oe;
        logic         exp_ready;
        logic         exp_err;
        logic [3:0]   exp_cfg;
        logic [W-1:0] exp_oe;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [3:0] d, input logic [W-1:0] oe,
                       input logic r, input logic e, input logic [3:0] c, input logic [W-1:0] xo);
        vec_t t;
        t.valid = v; t.data = d; t.oe = oe;
        t.exp_ready = r; t.exp_err = e; t.exp_cfg = c; t.exp_oe = xo;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise;
        logic [W-1:0] exp_o;

        // after-edge expectations: ready, err, configuration, north_oe_pad
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd0, 10'h000); // 0  SETTLE cnt0
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd0, 10'h000); // 1  ACTIVE, pad still blanked
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd0, 10'h3FF); // 2  OE re-enabled
        add(1, 4'd9, 10'h3FF, 1, 1, 4'd0, 10'h3FF); // 3  illegal -> err
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd0, 10'h3FF); // 4  err single cycle
        add(1, 4'd0, 10'h155, 1, 0, 4'd0, 10'h155); // 5  same code, no blank
        add(0, 4'd0, 10'h2AA, 1, 0, 4'd0, 10'h2AA); // 6
        add(1, 4'd2, 10'h3FF, 0, 0, 4'd0, 10'h000); // 7  switch 0->2, k+1
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd0, 10'h000); // 8  k+2
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd0, 10'h000); // 9  k+3
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd0, 10'h000); // 10 k+4
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd2, 10'h000); // 11 k+5 new cfg
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd2, 10'h000); // 12 k+6
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd2, 10'h000); // 13 k+7 ready
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd2, 10'h3FF); // 14 k+8 OE
        add(1, 4'd1, 10'h3FF, 0, 0, 4'd2, 10'h000); // 15 switch 2->1
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd2, 10'h000); // 16 held request ignored
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd2, 10'h000); // 17
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd2, 10'h000); // 18
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd1, 10'h000); // 19 cfg=1
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd1, 10'h000); // 20
        add(1, 4'd3, 10'h3FF, 1, 0, 4'd1, 10'h000); // 21 ready again
        add(1, 4'd3, 10'h3FF, 0, 0, 4'd1, 10'h000); // 22 switch 1->3 accepted
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd1, 10'h000); // 23
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd1, 10'h000); // 24
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd1, 10'h000); // 25
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd3, 10'h000); // 26 cfg=3
        add(0, 4'd0, 10'h3FF, 0, 0, 4'd3, 10'h000); // 27
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd3, 10'h000); // 28
        add(0, 4'd0, 10'h3FF, 1, 0, 4'd3, 10'h3FF); // 29

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 4'd0;
        o_sel  = 10'h3FF;
        oe_sel = 10'h3FF;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("reset_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("reset_busy", 32'(cfg_if.cfg_busy), 32'd1);
        chk("reset_err", 32'(cfg_if.cfg_err), 32'd0);
        chk("reset_cfg", 32'(configuration), 32'd0);
        chk("reset_oe_pad", 32'(oe_pad), 32'd0);
        chk("reset_o_pad", 32'(o_pad), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cfg_if.cfg_valid = tbl[i].valid;
            cfg_if.cfg_data  = tbl[i].data;
            oe_sel = tbl[i].oe;
            exp_o  = W'(i * 37 + 5);
            o_sel  = exp_o;
            @(posedge clk);
            #1;
            n_vec++;
            chk($sformatf("v%0d_ready", i), 32'(cfg_if.cfg_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("v%0d_busy", i), 32'(cfg_if.cfg_busy), 32'(!tbl[i].exp_ready));
            chk($sformatf("v%0d_err", i), 32'(cfg_if.cfg_err), 32'(tbl[i].exp_err));
            chk($sformatf("v%0d_cfg", i), 32'(configuration), 32'(tbl[i].exp_cfg));
            chk($sformatf("v%0d_oe_pad", i), 32'(oe_pad), 32'(tbl[i].exp_oe));
            chk($sformatf("v%0d_o_pad", i), 32'(o_pad), 32'(exp_o));
        end
        cfg_if.cfg_valid = 1'b0;

        // asynchronous reset while ACTIVE with cfg=3 and OE driven: outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("async_cfg", 32'(configuration), 32'd0);
        chk("async_oe_pad", 32'(oe_pad), 32'd0);
        chk("async_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("async_busy", 32'(cfg_if.cfg_busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rise = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (cfg_if.cfg_ready) begin
                rise = n;
                break;
            end
        end
        n_vec++;
        chk("reset_ready_latency", 32'(rise), 32'd2);

        // 0->3 request, reset two cycles into BLANK
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 4'd3;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
        n_vec++;
        chk("blank_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("blank_oe_pad", 32'(oe_pad), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midblank_cfg", 32'(configuration), 32'd0);
        chk("midblank_ready", 32'(cfg_if.cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            n_vec++;
            chk($sformatf("after_rst%0d_cfg", n), 32'(configuration), 32'd0);
            chk($sformatf("after_rst%0d_ready", n), 32'(cfg_if.cfg_ready), (n >= 2) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
